// File: rtl/fv_credit_sender.sv
// Credit-based sender feeding a push/pop FIFO: converts a valid/ready stream into pushes
// and never pushes unless a downstream slot was reserved by consuming a credit.
module fv_credit_sender #(
    parameter int MaxCredit      = 4,
    parameter int DataWidth      = 4,
    parameter int RegisterOutput = 1,
    localparam int CountWidth    = $clog2(MaxCredit + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [DataWidth-1:0]  src_data,
    output logic                  push,
    output logic [DataWidth-1:0]  push_data,
    input  logic                  credit_return,
    output logic [CountWidth-1:0] credit_count,
    output logic                  credits_empty
);

    localparam logic [CountWidth-1:0] MaxCount    = CountWidth'(MaxCredit);
    localparam logic [CountWidth:0]   MaxCountExt = (CountWidth + 1)'(MaxCredit);

    logic                accept;
    logic [CountWidth:0] count_next;

    // Only the registered count gates acceptance; a return this cycle helps next cycle.
    assign src_ready     = !rst && (credit_count != '0);
    assign accept        = src_valid && src_ready;
    assign credits_empty = (credit_count == '0);

    always_comb begin
        count_next = {1'b0, credit_count}
                   - (CountWidth + 1)'(accept)
                   + (CountWidth + 1)'(credit_return);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_count <= MaxCount;
        end else if (count_next > MaxCountExt) begin
            // A spurious return at full credit must not push the count past the FIFO depth.
            credit_count <= MaxCount;
        end else begin
            credit_count <= count_next[CountWidth-1:0];
        end
    end

    generate
        if (RegisterOutput != 0) begin : g_reg
            logic                 out_valid;
            logic [DataWidth-1:0] out_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end else begin
                    out_valid <= accept;
                    if (accept) out_data <= src_data;
                end
            end

            // Gated so a beat staged just before reset never reaches the FIFO.
            assign push      = out_valid && !rst;
            assign push_data = out_data;

            a_no_push_without_credit: assert property (@(posedge clk) disable iff (rst)
                push |-> $past(accept));
        end else begin : g_comb
            assign push      = accept;
            assign push_data = src_data;

            a_no_push_without_credit: assert property (@(posedge clk) disable iff (rst)
                push |-> accept);
        end
    endgenerate

    a_credit_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (credit_count == MaxCount) |-> !credit_return);

    a_src_stable: assert property (@(posedge clk) disable iff (rst)
        (src_valid && !src_ready) |=> (src_valid && $stable(src_data)));

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        credit_count <= MaxCount);

endmodule

// File: tb/tb_fv_credit_sender.sv
// Directed bench for fv_credit_sender (MaxCredit=4, DataWidth=4, registered output) with a
// closed-loop FIFO model; inputs change on negedge, outputs are sampled 1ns later.
module tb_fv_credit_sender;

    logic       clk = 1'b0;
    logic       rst;
    logic       src_valid;
    logic       src_ready;
    logic [3:0] src_data;
    logic       push;
    logic [3:0] push_data;
    logic       credit_return;
    logic [2:0] credit_count;
    logic       credits_empty;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fv_credit_sender #(
        .MaxCredit(4), .DataWidth(4), .RegisterOutput(1)
    ) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .push(push), .push_data(push_data),
        .credit_return(credit_return),
        .credit_count(credit_count), .credits_empty(credits_empty)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1; src_valid = 1'b0; credit_return = 1'b0; src_data = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; src_valid = 1'b1; src_data = 4'h3; credit_return = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (src_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst got=%b exp=0", src_ready); end
            total++; if (push !== 1'b0) begin bad++; $display("FAIL reset_push_in_rst got=%b exp=0", push); end
            tick();
        end
        rst = 1'b0; src_valid = 1'b0;
        #1;
        total++; if (credit_count !== 3'd4) begin bad++; $display("FAIL reset_count got=%0d exp=4", credit_count); end
        total++; if (src_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", src_ready); end
        total++; if (push !== 1'b0) begin bad++; $display("FAIL reset_push got=%b exp=0", push); end
        total++; if (credits_empty !== 1'b0) begin bad++; $display("FAIL reset_empty got=%b exp=0", credits_empty); end
        total++; if (push_data !== 4'h0) begin bad++; $display("FAIL reset_push_data got=%h exp=0", push_data); end
    endtask

    task automatic test_drain;
        do_reset();
        // Source holds its stalled beat (0x5) rather than advancing while not ready.
        for (int i = 1; i <= 6; i++) begin
            src_valid = 1'b1;
            src_data  = 4'((i <= 5) ? i : 5);
            #1;
            total++;
            if (src_ready !== (i <= 4)) begin bad++; $display("FAIL drain_ready cyc=%0d got=%b exp=%b", i, src_ready, (i <= 4)); end
            total++;
            if (push !== (i >= 2 && i <= 5)) begin bad++; $display("FAIL drain_push cyc=%0d got=%b exp=%b", i, push, (i >= 2 && i <= 5)); end
            if (i >= 2 && i <= 5) begin
                total++;
                if (push_data !== 4'(i - 1)) begin bad++; $display("FAIL drain_push_data cyc=%0d got=%h exp=%h", i, push_data, 4'(i - 1)); end
            end
            tick();
        end
        #1;
        total++; if (credits_empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b exp=1", credits_empty); end
        total++; if (credit_count !== 3'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", credit_count); end
    endtask

    task automatic test_simultaneous;
        do_reset();
        src_valid = 1'b1; src_data = 4'h7; tick();
        src_data = 4'h8; tick();
        src_valid = 1'b0;
        #1;
        total++; if (credit_count !== 3'd2) begin bad++; $display("FAIL simul_pre_count got=%0d exp=2", credit_count); end
        src_valid = 1'b1; src_data = 4'h9; credit_return = 1'b1;
        #1;
        total++; if (src_ready !== 1'b1) begin bad++; $display("FAIL simul_ready got=%b exp=1", src_ready); end
        tick();
        src_valid = 1'b0; credit_return = 1'b0;
        #1;
        total++; if (credit_count !== 3'd2) begin bad++; $display("FAIL simul_count got=%0d exp=2", credit_count); end
        total++; if (push !== 1'b1 || push_data !== 4'h9) begin bad++; $display("FAIL simul_push got=%b/%h exp=1/9", push, push_data); end
    endtask

    task automatic test_empty_return;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            src_valid = 1'b1; src_data = 4'(i); tick();
        end
        src_data = 4'hC; credit_return = 1'b1;
        #1;
        total++; if (src_ready !== 1'b0) begin bad++; $display("FAIL empty_ret_ready got=%b exp=0", src_ready); end
        total++; if (credits_empty !== 1'b1) begin bad++; $display("FAIL empty_ret_empty got=%b exp=1", credits_empty); end
        tick();
        credit_return = 1'b0;
        #1;
        total++; if (credit_count !== 3'd1) begin bad++; $display("FAIL empty_ret_count got=%0d exp=1", credit_count); end
        total++; if (src_ready !== 1'b1) begin bad++; $display("FAIL empty_ret_ready_next got=%b exp=1", src_ready); end
        tick();
        src_valid = 1'b0;
        #1;
        total++; if (push !== 1'b1 || push_data !== 4'hC) begin bad++; $display("FAIL empty_ret_push got=%b/%h exp=1/c", push, push_data); end
        total++; if (credit_count !== 3'd0) begin bad++; $display("FAIL empty_ret_count_after got=%0d exp=0", credit_count); end
    endtask

    task automatic test_reset_midflight;
        do_reset();
        src_valid = 1'b1; src_data = 4'hA;
        #1;
        total++; if (src_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", src_ready); end
        tick();
        src_valid = 1'b0; rst = 1'b1;
        #1;
        total++; if (push !== 1'b0) begin bad++; $display("FAIL midrst_push_in_rst got=%b exp=0", push); end
        tick();
        rst = 1'b0;
        #1;
        total++; if (push !== 1'b0) begin bad++; $display("FAIL midrst_push got=%b exp=0", push); end
        total++; if (credit_count !== 3'd4) begin bad++; $display("FAIL midrst_count got=%0d exp=4", credit_count); end
        total++; if (push_data !== 4'h0) begin bad++; $display("FAIL midrst_push_data got=%h exp=0", push_data); end
    endtask

    task automatic test_closed_loop;
        logic [3:0] sent_q[$];
        logic [3:0] fifo_q[$];
        logic [3:0] seq;
        logic [3:0] exp_d;
        logic       last_acc;
        logic       acc;
        logic       pop;
        int         exp_cnt;
        do_reset();
        seq = 4'h0; last_acc = 1'b0;
        for (int c = 0; c < 200; c++) begin
            pop = (fifo_q.size() > 0) && ($urandom_range(0, 1) == 1);
            credit_return = pop;
            if (!src_valid || last_acc) begin
                src_valid = ($urandom_range(0, 3) != 0);
                if (src_valid) begin src_data = seq; seq = seq + 4'h1; end
            end
            #1;
            exp_cnt = 4 - fifo_q.size() - (last_acc ? 1 : 0);
            total++;
            if (credit_count !== 3'(exp_cnt)) begin bad++; $display("FAIL loop_count cyc=%0d got=%0d exp=%0d", c, credit_count, exp_cnt); end
            total++;
            if (push !== last_acc) begin bad++; $display("FAIL loop_push cyc=%0d got=%b exp=%b", c, push, last_acc); end
            if (last_acc) begin
                exp_d = sent_q.pop_front();
                total++;
                if (push_data !== exp_d) begin bad++; $display("FAIL loop_order cyc=%0d got=%h exp=%h", c, push_data, exp_d); end
                total++;
                if (fifo_q.size() >= 4) begin bad++; $display("FAIL loop_fifo_full cyc=%0d occ=%0d max=3", c, fifo_q.size()); end
            end
            acc = src_valid && (exp_cnt != 0);
            total++;
            if (src_ready !== (exp_cnt != 0)) begin bad++; $display("FAIL loop_ready cyc=%0d got=%b exp=%b", c, src_ready, (exp_cnt != 0)); end
            if (pop) void'(fifo_q.pop_front());
            if (last_acc) fifo_q.push_back(exp_d);
            if (acc) sent_q.push_back(src_data);
            last_acc = acc;
            tick();
        end
        do_reset();
    endtask

    initial begin
        rst = 1'b1; src_valid = 1'b0; src_data = '0; credit_return = 1'b0;
        @(negedge clk);
        test_reset();
        test_drain();
        test_simultaneous();
        test_empty_return();
        test_reset_midflight();
        test_closed_loop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
